axi_wr_arbiter: RTL and testbench

- Shares the single AXI write port (AW/W/B) between two line-sized write requesters: requester 0 = fill path (fill FIFO drain), requester 1 = dirty-victim writeback path.
- Grants round-robin, issues one single-beat write per grant and routes B responses back by ID.
- Caps outstanding writes per requester.
- Sits between the cache controller's fill/writeback buffers and the DRAM-side AXI write interface.

---
 rtl/cache_axi_pkg.sv | 18 +
 rtl/rr_arb2.sv | 16 +
 rtl/axi_wr_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_axi_wr_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_axi_pkg.sv
// Shared widths, AXI ID assignments and arbiter state encoding for the
// cache-to-DRAM write path.
package cache_axi_pkg;

  localparam int unsigned ADDR_W        = 32;
  localparam int unsigned DATA_W        = 512;
  localparam int unsigned ID_W          = 4;
  localparam int unsigned OFFSET_W      = 6;
  localparam int unsigned AXI_FILL_ID   = 0;
  localparam int unsigned AXI_WB_ID     = 1;
  localparam int unsigned AXI_MAX_OUTST = 4;

  typedef enum logic {
    S_IDLE,
    S_ISSUE
  } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone eligible requester wins, a tie goes to
// the requester that was not granted last. Purely combinational.
module rr_arb2 (
  input  logic [1:0] eligible_i,
  input  logic       last_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = eligible_i;
    if (&eligible_i) begin
      grant_o = last_i ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Shares one AXI write port between the fill path (req0) and the victim
// writeback path (req1); one single-beat write per grant, B routed by ID.
module axi_wr_arbiter
  import cache_axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = ADDR_W,
  parameter int unsigned DATA_WIDTH   = DATA_W,
  parameter int unsigned ID_WIDTH     = ID_W,
  parameter int unsigned OFFSET_WIDTH = OFFSET_W,
  parameter int unsigned FILL_ID      = AXI_FILL_ID,
  parameter int unsigned WB_ID        = AXI_WB_ID,
  parameter int unsigned MAX_OUTST    = AXI_MAX_OUTST
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid_i,
  input  logic [ADDR_WIDTH-1:0] req0_addr_i,
  input  logic [DATA_WIDTH-1:0] req0_data_i,
  output logic                  req0_ready_o,
  output logic                  req0_bdone_o,
  input  logic                  req1_valid_i,
  input  logic [ADDR_WIDTH-1:0] req1_addr_i,
  input  logic [DATA_WIDTH-1:0] req1_data_i,
  output logic                  req1_ready_o,
  output logic                  req1_bdone_o,
  output logic [ID_WIDTH-1:0]   awid_o,
  output logic [ADDR_WIDTH-1:0] awaddr_o,
  output logic                  awvalid_o,
  input  logic                  awready_i,
  output logic [ID_WIDTH-1:0]   wid_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic                  wlast_o,
  output logic                  wvalid_o,
  input  logic                  wready_i,
  input  logic [ID_WIDTH-1:0]   bid_i,
  input  logic [1:0]            bresp_i,
  input  logic                  bvalid_i,
  output logic                  bready_o,
  output logic                  err_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);
  localparam logic [CNT_W-1:0]      MAX_C       = CNT_W'(MAX_OUTST);
  localparam logic [ID_WIDTH-1:0]   FILL_ID_C   = ID_WIDTH'(FILL_ID);
  localparam logic [ID_WIDTH-1:0]   WB_ID_C     = ID_WIDTH'(WB_ID);
  localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'((64'd1 << OFFSET_WIDTH) - 64'd1);

  arb_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic                  sel_q, sel_d;
  logic                  last_q, last_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      cnt0_q, cnt0_d;
  logic [CNT_W-1:0]      cnt1_q, cnt1_d;

  logic [1:0] eligible;
  logic [1:0] grant;
  logic       aw_now, w_now;
  logic       inc0, inc1;
  logic       b_fire, b_hit0, b_hit1;

  assign eligible = {req1_valid_i && (cnt1_q < MAX_C),
                     req0_valid_i && (cnt0_q < MAX_C)};

  rr_arb2 u_rr_arb2 (
    .eligible_i (eligible),
    .last_i     (last_q),
    .grant_o    (grant)
  );

  assign bready_o = ~rst;
  assign awaddr_o = addr_q;
  assign wdata_o  = data_q;
  assign awid_o   = id_q;
  assign wid_o    = id_q;
  assign wlast_o  = wvalid_o;
  assign err_o    = err_q;

  // Responses for an unknown ID or an idle counter are dropped, never routed.
  assign b_fire       = bvalid_i & bready_o;
  assign b_hit0       = b_fire && (bid_i == FILL_ID_C) && (cnt0_q != '0);
  assign b_hit1       = b_fire && (bid_i == WB_ID_C) && (cnt1_q != '0);
  assign req0_bdone_o = b_hit0;
  assign req1_bdone_o = b_hit1;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    id_d         = id_q;
    sel_d        = sel_q;
    last_d       = last_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    inc0         = 1'b0;
    inc1         = 1'b0;
    awvalid_o    = (state_q == S_ISSUE) && !aw_done_q;
    wvalid_o     = (state_q == S_ISSUE) && !w_done_q;
    aw_now       = aw_done_q | (awvalid_o & awready_i);
    w_now        = w_done_q | (wvalid_o & wready_i);

    case (state_q)
      S_IDLE: begin
        if (|grant) begin
          req0_ready_o = grant[0] & ~rst;
          req1_ready_o = grant[1] & ~rst;
          sel_d        = grant[1];
          last_d       = grant[1];
          addr_d       = (grant[1] ? req1_addr_i : req0_addr_i) & ~OFFSET_MASK;
          data_d       = grant[1] ? req1_data_i : req0_data_i;
          id_d         = grant[1] ? WB_ID_C : FILL_ID_C;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // AW and W retire independently; leave only once both have.
        if (aw_now && w_now) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          inc0      = ~sel_q;
          inc1      = sel_q;
          state_d   = S_IDLE;
        end else begin
          aw_done_d = aw_now;
          w_done_d  = w_now;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    case ({inc0, b_hit0})
      2'b10:   cnt0_d = cnt0_q + CNT_W'(1);
      2'b01:   cnt0_d = cnt0_q - CNT_W'(1);
      default: cnt0_d = cnt0_q;
    endcase
    case ({inc1, b_hit1})
      2'b10:   cnt1_d = cnt1_q + CNT_W'(1);
      2'b01:   cnt1_d = cnt1_q - CNT_W'(1);
      default: cnt1_d = cnt1_q;
    endcase
    err_d = err_q | (b_fire & ((bresp_i != 2'b00) | ~(b_hit0 | b_hit1)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      id_q      <= '0;
      sel_q     <= 1'b0;
      last_q    <= 1'b1;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
      cnt0_q    <= '0;
      cnt1_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      id_q      <= id_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      err_q     <= err_d;
      cnt0_q    <= cnt0_d;
      cnt1_q    <= cnt1_d;
    end
  end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Self-checking bench for axi_wr_arbiter: expected AW/W beats are queued when
// a grant is expected and popped by a monitor when the handshakes occur.
module tb_axi_wr_arbiter;

  logic         clk;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic [31:0]  req0_addr, req1_addr;
  logic [511:0] req0_data, req1_data;
  logic         req0_ready, req1_ready, req0_bdone, req1_bdone;
  logic [3:0]   awid, wid, bid;
  logic [31:0]  awaddr;
  logic [511:0] wdata;
  logic         awvalid, awready, wlast, wvalid, wready;
  logic [1:0]   bresp;
  logic         bvalid, bready, err;

  typedef struct {
    logic [3:0]   id;
    logic [31:0]  addr;
    logic [511:0] data;
  } beat_t;

  beat_t aw_q[$];
  beat_t w_q[$];

  int check_count = 0;
  int error_count = 0;
  int cnt0_m = 0;
  int cnt1_m = 0;
  bit err_m  = 0;
  bit last_m = 1;

  axi_wr_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid_i (req0_valid),
    .req0_addr_i  (req0_addr),
    .req0_data_i  (req0_data),
    .req0_ready_o (req0_ready),
    .req0_bdone_o (req0_bdone),
    .req1_valid_i (req1_valid),
    .req1_addr_i  (req1_addr),
    .req1_data_i  (req1_data),
    .req1_ready_o (req1_ready),
    .req1_bdone_o (req1_bdone),
    .awid_o       (awid),
    .awaddr_o     (awaddr),
    .awvalid_o    (awvalid),
    .awready_i    (awready),
    .wid_o        (wid),
    .wdata_o      (wdata),
    .wlast_o      (wlast),
    .wvalid_o     (wvalid),
    .wready_i     (wready),
    .bid_i        (bid),
    .bresp_i      (bresp),
    .bvalid_i     (bvalid),
    .bready_o     (bready),
    .err_o        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [511:0] actual,
                             input logic [511:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // One IDLE cycle: check which ready fires and queue the beat it should issue.
  task automatic applyStimulus(input logic exp_r0, input logic exp_r1, input string tag);
    beat_t b;
    @(negedge clk);
    checkOutput({tag, "_rdy0"}, req0_ready, exp_r0);
    checkOutput({tag, "_rdy1"}, req1_ready, exp_r1);
    if (exp_r0) begin
      b.id = 4'd0; b.addr = req0_addr & ~32'h3F; b.data = req0_data;
      aw_q.push_back(b); w_q.push_back(b);
      cnt0_m++; last_m = 1'b0;
    end else if (exp_r1) begin
      b.id = 4'd1; b.addr = req1_addr & ~32'h3F; b.data = req1_data;
      aw_q.push_back(b); w_q.push_back(b);
      cnt1_m++; last_m = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic issue_cycle(input string tag);
    @(negedge clk);
    checkOutput({tag, "_issue_rdy"}, {req1_ready, req0_ready}, 2'b00);
    checkOutput({tag, "_issue_awv"}, awvalid, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic send_b(input logic [3:0] id, input logic [1:0] resp, input string tag);
    bit e0, e1;
    bvalid = 1'b1; bid = id; bresp = resp;
    e0 = (id == 4'd0) && (cnt0_m > 0);
    e1 = (id == 4'd1) && (cnt1_m > 0);
    @(negedge clk);
    checkOutput({tag, "_bdone0"}, req0_bdone, e0);
    checkOutput({tag, "_bdone1"}, req1_bdone, e1);
    if (e0) cnt0_m--;
    if (e1) cnt1_m--;
    if (resp != 2'b00 || !(e0 || e1)) err_m = 1'b1;
    @(posedge clk); #1;
    bvalid = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_err"}, err, err_m);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (!rst && awvalid && awready) begin
      if (aw_q.size() == 0) checkOutput("aw_unexpected", 1'b1, 1'b0);
      else begin
        e = aw_q.pop_front();
        checkOutput("sb_awid", awid, e.id);
        checkOutput("sb_awaddr", awaddr, e.addr);
      end
    end
    if (!rst && wvalid && wready) begin
      if (w_q.size() == 0) checkOutput("w_unexpected", 1'b1, 1'b0);
      else begin
        e = w_q.pop_front();
        checkOutput("sb_wid", wid, e.id);
        checkOutput("sb_wdata", wdata, e.data);
        checkOutput("sb_wlast", wlast, 1'b1);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0;
    req0_addr = '0; req1_addr = '0; req0_data = '0; req1_data = '0;
    awready = 0; wready = 0; bid = '0; bresp = '0; bvalid = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_awvalid", awvalid, 1'b0);
    checkOutput("rst_wvalid", wvalid, 1'b0);
    checkOutput("rst_bready", bready, 1'b0);
    checkOutput("rst_err", err, 1'b0);
    checkOutput("rst_awaddr", awaddr, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("run_bready", bready, 1'b1);
    @(posedge clk); #1;

    // Single fill request, offset bits cleared on AW.
    awready = 1; wready = 1;
    req0_valid = 1; req0_addr = 32'h1234_5678; req0_data = {16{32'hA5A5_0001}};
    applyStimulus(1, 0, "t1_grant");
    req0_valid = 0;
    @(negedge clk);
    checkOutput("t1_awaddr", awaddr, 32'h1234_5640);
    checkOutput("t1_awid", awid, 4'd0);
    checkOutput("t1_wvalid", wvalid, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("t1_idle_awv", awvalid, 1'b0);
    checkOutput("t1_idle_wv", wvalid, 1'b0);
    @(posedge clk); #1;

    // Both requesters continuously valid: grants alternate.
    req0_valid = 1; req0_addr = 32'h0000_1000; req0_data = {16{32'h0000_00F0}};
    req1_valid = 1; req1_addr = 32'h0000_2004; req1_data = {16{32'h0000_00F1}};
    for (int k = 0; k < 4; k++) begin
      if (last_m) applyStimulus(1, 0, "t2_rr");
      else        applyStimulus(0, 1, "t2_rr");
      issue_cycle("t2");
    end
    req0_valid = 0; req1_valid = 0;
    for (int k = 0; k < 3; k++) send_b(4'd0, 2'b00, "t2_b0");
    for (int k = 0; k < 2; k++) send_b(4'd1, 2'b00, "t2_b1");

    // AW stalled three cycles while W completes at once.
    awready = 0; wready = 1;
    req0_valid = 1; req0_addr = 32'hCAFE_F00D; req0_data = {16{32'h3333_0003}};
    applyStimulus(1, 0, "t3_grant");
    req0_valid = 0;
    for (int c = 1; c <= 4; c++) begin
      if (c == 2) begin
        req1_valid = 1; req1_addr = 32'h0BAD_0040; req1_data = {16{32'h4444_0004}};
      end
      if (c == 4) awready = 1;
      @(negedge clk);
      checkOutput("t3_awvalid", awvalid, 1'b1);
      checkOutput("t3_awaddr", awaddr, 32'hCAFE_F000);
      checkOutput("t3_wvalid", wvalid, c == 1);
      checkOutput("t3_rdy1_busy", req1_ready, 1'b0);
      @(posedge clk); #1;
    end
    applyStimulus(0, 1, "t3_idle5");
    req1_valid = 0;
    issue_cycle("t3");
    send_b(4'd0, 2'b00, "t3_b0");
    send_b(4'd1, 2'b00, "t3_b1");

    // Outstanding cap on req0; req1 keeps getting served.
    req0_valid = 1; req0_addr = 32'h0001_0000; req0_data = {16{32'h5555_0005}};
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 0, "t4_fill");
      issue_cycle("t4");
    end
    applyStimulus(0, 0, "t4_cap");
    req1_valid = 1; req1_addr = 32'h0002_0080; req1_data = {16{32'h6666_0006}};
    applyStimulus(0, 1, "t4_wb");
    req1_valid = 0;
    issue_cycle("t4_wb");
    bvalid = 1; bid = 4'd0; bresp = 2'b00;
    @(negedge clk);
    checkOutput("t4_bdone0", req0_bdone, 1'b1);
    checkOutput("t4_still_capped", req0_ready, 1'b0);
    cnt0_m--;
    @(posedge clk); #1;
    bvalid = 0;
    applyStimulus(1, 0, "t4_regrant");
    req0_valid = 0;
    issue_cycle("t4_regrant");

    // Unknown ID sets sticky error and leaves counters alone.
    send_b(4'd7, 2'b00, "t5_bid7");
    send_b(4'd1, 2'b00, "t5_b1");
    send_b(4'd1, 2'b00, "t5_b1_empty");
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("t5_err_sticky", err, 1'b1);
    @(posedge clk); #1;

    // Reset while a write is stuck in ISSUE.
    awready = 0; wready = 0;
    req1_valid = 1; req1_addr = 32'h0003_0000; req1_data = {16{32'h7777_0007}};
    applyStimulus(0, 1, "t6_grant");
    req1_valid = 0;
    rst = 1;
    @(negedge clk);
    checkOutput("t6_awv_before", awvalid, 1'b1);
    @(posedge clk); #1;
    rst = 0;
    aw_q.delete(); w_q.delete();
    cnt0_m = 0; cnt1_m = 0; err_m = 0; last_m = 1;
    @(negedge clk);
    checkOutput("t6_awvalid", awvalid, 1'b0);
    checkOutput("t6_wvalid", wvalid, 1'b0);
    checkOutput("t6_err", err, 1'b0);
    @(posedge clk); #1;
    awready = 1; wready = 1;
    req0_valid = 1; req0_addr = 32'h0004_00FF; req0_data = {16{32'h8888_0008}};
    req1_valid = 1;
    applyStimulus(1, 0, "t6_first");
    req0_valid = 0; req1_valid = 0;
    issue_cycle("t6");
    send_b(4'd0, 2'b10, "t6_slverr");
    send_b(4'd0, 2'b00, "t6_cnt_zero");

    @(negedge clk);
    checkOutput("aw_q_drained", aw_q.size() == 0, 1'b1);
    checkOutput("w_q_drained", w_q.size() == 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
